alu_muldiv_seq: RTL and testbench
=================================

# alu_muldiv_seq

Multi-cycle sequencer that computes 32-bit unsigned-operand multiply (low word) and unsigned divide/remainder by driving the shared single-cycle ALU iteratively. It sits beside the ALU in the datapath. While `busy` is high it owns the ALU operand and opcode inputs, and it exchanges operands with the core through a start/done handshake. It adds no arithmetic hardware of its own beyond shift registers and a step counter.

## Interface
- `XLEN`, 32: operand and result width; the step count equals `XLEN`.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 MUL (low 32 bits of a*b), 01 reserved (treated as MUL), 10 DIVU (a/b), 11 REMU (a%b).
- `operand_a`  in  XLEN  multiplicand or dividend; sampled with `start`.
- `operand_b`  in  XLEN  multiplier or divisor; sampled with `start`.
- `busy`  out  1  high in MUL_RUN, DIV_CMP and DIV_SUB.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  XLEN  registered; held until the next accepted `start`.
- `div_by_zero`  out  1  registered; high with `done` when the op was DIVU or REMU with b==0; held with `result`.
- `alu_a`, `alu_b`  out  XLEN  ALU operands.
- `alu_op`  out  3  ALU opcode. Encodings used: add 000, sub 001, sltu 101.
- `alu_result`  in  XLEN  combinational ALU result for the current `alu_*` drive.

## Operation
- States: IDLE, MUL_RUN, DIV_CMP, DIV_SUB, DONE. Reset enters IDLE.
- IDLE/DONE with `start`=1:
  - Latch operands and `op`, clear `cnt` (log2(XLEN)+1 bits).
  - MUL → MUL_RUN with acc=0, mcand=a, mplier=b.
  - DIVU/REMU → DIV_CMP with rem=0, dvd=a, dvs=b, quo=0.
- DONE with `start`=0 → IDLE.
- `start` in any RUN state is ignored; no queuing.
- MUL_RUN, one ALU cycle per step:
  - Drive `alu_a`=acc, `alu_b`=mplier[0] ? mcand : 0, `alu_op`=add.
  - At the edge: acc←alu_result; mcand←mcand<<1; mplier←mplier>>1; cnt++.
  - After step XLEN-1 → DONE with result=acc.
  - Overflow above bit XLEN-1 is discarded (mod 2^XLEN).
- DIV, two ALU cycles per bit. Let r' = {rem[XLEN-2:0], dvd[XLEN-1]} and top = rem[XLEN-1] (the 33rd bit of the shifted remainder).
  - DIV_CMP: `alu_a`=r', `alu_b`=dvs, `alu_op`=sltu. At the edge, latch ge = top | ~alu_result[0] and go to DIV_SUB.
  - DIV_SUB: `alu_a`=r', `alu_b`=dvs, `alu_op`=sub. At the edge:
    - rem←ge ? alu_result : r'
    - quo←{quo[XLEN-2:0], ge}
    - dvd←dvd<<1; cnt++
    - Then go to DIV_CMP, or to DONE after bit XLEN-1.
  - At DONE: result = quo for DIVU, rem for REMU.
- Divide by zero: no special path. The algorithm naturally yields quo=all-ones and rem=dividend. `div_by_zero` is set from (b==0) latched at `start`.
- IDLE and DONE ALU drive: `alu_a`=0, `alu_b`=0, `alu_op`=add.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, `div_by_zero`=0, `alu_a`=0, `alu_b`=0, `alu_op`=000, state IDLE.
- Reset is asynchronous. Asserting `rst_n` low mid-operation aborts the operation immediately and no `done` is produced.
- `busy` rises on the edge that accepts `start` and falls on the edge that enters DONE.
- `done` is high for exactly one cycle.
- Latency from the accepting edge to the edge that raises `done`:
  - MUL: XLEN edges (32).
  - DIVU/REMU: 2·XLEN edges (64).
  - Latency is fixed and independent of operand values.
- Back-to-back: `start` asserted during the DONE cycle is accepted. `busy` rises on the same edge that `done` falls; there is no idle bubble.
- `result` and `div_by_zero` update only on entry to DONE and are stable between operations.
- ALU outputs are combinational from registered state only; no input-to-output path exists except through the ALU.

## Test plan
- MUL a=7, b=6 → `done` exactly 32 edges after start, `result`=42, `div_by_zero`=0.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF → `result`=0x00000001. Then MUL a=0x10000, b=0x10000 → `result`=0.
- DIVU a=100, b=7 → `result`=14 after 64 edges. REMU with the same operands → `result`=2. Run REMU back-to-back with `start` held in the DONE cycle; verify no bubble.
- DIVU a=0xFFFFFFFF, b=0x80000001 → quotient 1. REMU on the same operands → 0x7FFFFFFE. This exercises the top-bit (ge forced) path.
- DIVU a=0x1234, b=0 → `result`=0xFFFFFFFF, `div_by_zero`=1. REMU a=0x1234, b=0 → `result`=0x1234, `div_by_zero`=1.
- Pulse `start` with new operands at edge 10 of a MUL → ignored, and the original result is produced. Drop `rst_n` at edge 20 of a DIVU → all outputs return to reset values at once, with no `done`.

Source files
------------

// File: rtl/alu_muldiv_seq_if.sv
// Core-side handshake bundle for alu_muldiv_seq.
//   master (core):      drives start, op, operand_a, operand_b;
//                       observes busy, done, result, div_by_zero.
//   slave (sequencer):  the mirror image.
interface alu_muldiv_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer that borrows the shared ALU.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       start/op/operands in; busy/done/result/div_by_zero out
//   alu_a_o, alu_b_o  ALU operands (driven from registered state only)
//   alu_op_o          ALU opcode: add 000, sub 001, sltu 101
//   alu_result_i      combinational ALU result for the current drive
// MUL: shift-and-add, one ALU add per bit (XLEN cycles).
// DIV: restoring division, sltu compare then sub per bit (2*XLEN cycles).
module alu_muldiv_seq #(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_muldiv_seq_if.slave     bus,
    output logic [XLEN-1:0]     alu_a_o,
    output logic [XLEN-1:0]     alu_b_o,
    output logic [2:0]          alu_op_o,
    input  logic [XLEN-1:0]     alu_result_i
);
    localparam int unsigned CW = $clog2(XLEN) + 1;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] MUL_RUN = 3'd1;
    localparam logic [2:0] DIV_CMP = 3'd2;
    localparam logic [2:0] DIV_SUB = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b101;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;       // MUL partial product
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] rem_q, rem_d;       // DIV partial remainder
    logic [XLEN-1:0] dvd_q, dvd_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic            ge_q, ge_d;
    logic            is_rem_q, is_rem_d;
    logic            dbz_q, dbz_d;       // b==0 captured at start
    logic [XLEN-1:0] result_q, result_d;
    logic            dbz_out_q, dbz_out_d;

    logic [XLEN-1:0] r_sh;
    logic            last;

    // Remainder shifted left by one with the next dividend bit; its lost
    // MSB (rem_q[XLEN-1]) forces ge since the true value then exceeds dvs.
    assign r_sh = {rem_q[XLEN-2:0], dvd_q[XLEN-1]};
    assign last = (cnt_q == CW'(XLEN - 1));

    assign bus.busy        = (state_q == MUL_RUN) || (state_q == DIV_CMP) || (state_q == DIV_SUB);
    assign bus.done        = (state_q == DONE);
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_out_q;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = ALU_ADD;
        case (state_q)
            MUL_RUN: begin
                alu_a_o = acc_q;
                alu_b_o = mplier_q[0] ? mcand_q : '0;
            end
            DIV_CMP: begin
                alu_a_o  = r_sh;
                alu_b_o  = dvs_q;
                alu_op_o = ALU_SLTU;
            end
            DIV_SUB: begin
                alu_a_o  = r_sh;
                alu_b_o  = dvs_q;
                alu_op_o = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        quo_d     = quo_q;
        ge_d      = ge_q;
        is_rem_d  = is_rem_q;
        dbz_d     = dbz_q;
        result_d  = result_q;
        dbz_out_d = dbz_out_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    cnt_d    = '0;
                    is_rem_d = bus.op[1] & bus.op[0];
                    dbz_d    = bus.op[1] && (bus.operand_b == '0);
                    if (bus.op[1]) begin
                        rem_d   = '0;
                        dvd_d   = bus.operand_a;
                        dvs_d   = bus.operand_b;
                        quo_d   = '0;
                        state_d = DIV_CMP;
                    end else begin
                        acc_d    = '0;
                        mcand_d  = bus.operand_a;
                        mplier_d = bus.operand_b;
                        state_d  = MUL_RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            MUL_RUN: begin
                acc_d    = alu_result_i;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    result_d  = alu_result_i;
                    dbz_out_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DIV_CMP: begin
                ge_d    = rem_q[XLEN-1] | ~alu_result_i[0];
                state_d = DIV_SUB;
            end
            DIV_SUB: begin
                rem_d = ge_q ? alu_result_i : r_sh;
                quo_d = {quo_q[XLEN-2:0], ge_q};
                dvd_d = dvd_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    result_d  = is_rem_q ? rem_d : quo_d;
                    dbz_out_d = dbz_q;
                    state_d   = DONE;
                end else begin
                    state_d = DIV_CMP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            quo_q     <= '0;
            ge_q      <= 1'b0;
            is_rem_q  <= 1'b0;
            dbz_q     <= 1'b0;
            result_q  <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            quo_q     <= quo_d;
            ge_q      <= ge_d;
            is_rem_q  <= is_rem_d;
            dbz_q     <= dbz_d;
            result_q  <= result_d;
            dbz_out_q <= dbz_out_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq with a behavioural ALU alongside.
module tb_alu_muldiv_seq;
    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [2:0]      alu_op;

    alu_muldiv_seq_if #(.XLEN(XLEN)) bus ();

    alu_muldiv_seq #(.XLEN(XLEN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_op_o     (alu_op),
        .alu_result_i (alu_result)
    );

    // Shared single-cycle ALU
    always_comb begin
        case (alu_op)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b101:  alu_result = (alu_a < alu_b) ? 32'd1 : 32'd0;
            default: alu_result = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        dbz;
        int unsigned done_cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive at the current negedge; the next posedge is the accepting edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic dbz, input bit expect_done);
        exp_t e;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        if (expect_done) begin
            e.res      = res;
            e.dbz      = dbz;
            e.done_cyc = cyc + 1 + (op[1] ? 64 : 32);
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus.done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    // Monitor: pops and compares whenever done is presented
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=%h required=none", bus.result);
                end else begin
                    e = sb.pop_front();
                    chk("result", bus.result, e.res);
                    chk("div_by_zero", {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
                    chk("latency_cycle", cyc, e.done_cyc);
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_alu_op", {29'b0, alu_op}, 32'd0);
        rst_n = 1'b1;

        // MUL basic, overflow wrap, and all-zero low word
        @(negedge clk); issue(2'b00, 32'd7, 32'd6, 32'd42, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0;
        chk("busy_after_start", {31'b0, bus.busy}, 32'd1);
        chk("alu_op_mul", {29'b0, alu_op}, 32'd0);
        wait_done("mul7x6");
        @(negedge clk); issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("mul_ff");
        @(negedge clk); issue(2'b01, 32'h00010000, 32'h00010000, 32'h0, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("mul_2p32");

        // DIVU then REMU back-to-back, start held in the DONE cycle
        @(negedge clk); issue(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0;
        chk("alu_op_div_cmp", {29'b0, alu_op}, 32'd5);
        @(negedge clk);
        chk("alu_op_div_sub", {29'b0, alu_op}, 32'd1);
        wait_done("divu100_7");
        issue(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0;
        chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
        chk("b2b_done_low", {31'b0, bus.done}, 32'd0);
        wait_done("remu100_7");

        // Top-bit forced ge path
        @(negedge clk); issue(2'b10, 32'hFFFFFFFF, 32'h80000001, 32'h1, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("divu_top");
        @(negedge clk); issue(2'b11, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("remu_top");

        // Divide by zero
        @(negedge clk); issue(2'b10, 32'h1234, 32'h0, 32'hFFFFFFFF, 1'b1, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("divu_dbz");
        @(negedge clk); issue(2'b11, 32'h1234, 32'h0, 32'h1234, 1'b1, 1);
        @(negedge clk); bus.start = 1'b0; wait_done("remu_dbz");

        // Reset abort mid-DIVU: no done, outputs return to reset values at once
        @(negedge clk); issue(2'b10, 32'd100, 32'd7, 32'd0, 1'b0, 0);
        @(negedge clk); bus.start = 1'b0;
        repeat (18) @(negedge clk);
        chk("pre_reset_busy", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'b0, bus.busy}, 32'd0);
        chk("abort_done", {31'b0, bus.done}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_dbz", {31'b0, bus.div_by_zero}, 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        chk("abort_alu_b", alu_b, 32'd0);
        chk("abort_alu_op", {29'b0, alu_op}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (70) @(negedge clk);
        chk("abort_idle", {31'b0, bus.busy}, 32'd0);

        // start during MUL_RUN is ignored
        @(negedge clk); issue(2'b00, 32'd5, 32'd9, 32'd45, 1'b0, 1);
        @(negedge clk); bus.start = 1'b0;
        repeat (8) @(negedge clk);
        issue(2'b10, 32'd1000, 32'd3, 32'd0, 1'b0, 0);
        @(negedge clk); bus.start = 1'b0;
        wait_done("mul_ignore");

        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
